noise_est_block_reader: RTL and testbench
=========================================

// Module: noise_est_block_reader
// PURPOSE
// Front-end of the noise-estimation path: on frame_ready, fetches a frame from memory
// block by block (BLOCK_SIZE x BLOCK_SIZE pixels, raster block order). Each block row is
// one AXI4 INCR read burst. Merges the block-address sequencer and the AXI read master.
// Streams accepted beats to the noise estimator with enable/start-of-frame markers.
// PARAMETERS
// ADDR_WIDTH  32  AXI address width (byte address)
// DATA_WIDTH  32  AXI data width; one pixel per beat
// BLOCK_SIZE  4   block edge in pixels; burst length in beats
// BASE_ADDR   0   byte address of pixel (0,0) of the frame
// PORTS
// clk                  in   1           clock, rising edge
// rst_n                in   1           async active-low reset
// frame_height         in   16          frame rows in pixels, multiple of BLOCK_SIZE
// frame_width          in   16          frame columns in pixels, multiple of BLOCK_SIZE
// frame_ready          in   1           pulse: frame present in memory, start reading
// araddr               out  ADDR_WIDTH  AR address
// arlen                out  8           AR burst length (always BLOCK_SIZE-1)
// arsize               out  3           AR beat size (always log2(DATA_WIDTH/8))
// arburst              out  2           AR burst type (always 2'b01, INCR)
// arvalid              out  1           AR valid
// arready              in   1           AR ready
// rdata                in   DATA_WIDTH  R data
// rresp                in   2           R response (ignored)
// rvalid / rlast       in   1           R valid / last beat of burst
// rready               out  1           R ready
// pixel_out            out  DATA_WIDTH  registered copy of accepted rdata
// noise_estimation_en  out  1           pixel_out valid this cycle
// start_of_frame       out  1           with first pixel_out of frame
// base_addr_out        out  ADDR_WIDTH  byte address of top-left pixel of current block
// frame_done           out  1           1-cycle pulse after last beat of frame
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0, FSM IDLE, counters 0; arlen/arsize/arburst constant.
// - FSM: IDLE -> AR -> R -> NEXT -> (AR | DONE) -> IDLE.
//   IDLE: wait frame_ready=1; clear block_row, block_col, line; go AR.
//   AR: arvalid=1, araddr = BASE_ADDR + ((block_row*BS+line)*frame_width + block_col*BS)*(DATA_WIDTH/8);
//       hold araddr/arvalid stable until arvalid&arready sampled; then arvalid=0, go R.
//   R: rready=1; each rvalid&rready beat -> next cycle pixel_out=rdata, noise_estimation_en=1;
//      beat with rlast=1 -> go NEXT. Beats without rvalid produce no output.
//   NEXT (1 cycle): line++; at line=BS-1 wrap to 0 and block_col++; at last column wrap to 0
//      and block_row++; after the last line of the last block go DONE, else AR.
//   DONE: frame_done=1 for one cycle, go IDLE.
// - start_of_frame=1 only on the cycle pixel_out holds the first beat of the frame.
// - base_addr_out updated on entering AR for line 0 of each block; held otherwise.
// - Latency: arvalid asserts 1 cycle after frame_ready; data output 1 cycle after beat acceptance.
// - Beats per frame = frame_height*frame_width; bursts = frame_height*frame_width/BS.
// - frame_ready while not IDLE is ignored (no queueing).
// - rlast is trusted; the beat count is not checked. rresp is ignored.
// - Address arithmetic is ADDR_WIDTH wide; overflow wraps modulo 2^ADDR_WIDTH.
// - Reset mid-burst aborts at once; no AR reissued until the next frame_ready after release.
// TESTING
// 1) 8x8 frame, BS=4, memory word i = i+1, slave arready delayed 1 cycle -> bursts:
//    araddr=0,32,64,96 (block 0), then 16,48,80,112 (block 1), then 128..; arlen=3, arsize=2, arburst=1.
// 2) Same frame -> 64 noise_estimation_en pulses; pixel_out sequence 1,2,3,4,9,10,11,12,...;
//    start_of_frame with first pixel value 1; frame_done once after pixel 64.
// 3) arready held low 5 cycles -> araddr/arvalid stable; exactly one AR handshake per burst.
// 4) rvalid gaps inside a burst -> no output on gap cycles; ordering preserved.
// 5) frame_ready pulsed mid-frame -> ignored; total 16 bursts.
// 6) rst_n low during a burst -> outputs 0 immediately; a new frame_ready restarts at araddr=0.

Source files
------------

// File: rtl/noise_est_block_reader_if.sv
// noise_est_block_reader_if: AXI4 read-address and read-data channels between the block reader and memory.
interface noise_est_block_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/noise_est_block_reader.sv
// noise_est_block_reader: fetches a frame block by block (one INCR burst per block row) and streams pixels out.
module noise_est_block_reader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BLOCK_SIZE = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             frame_height,
    input  logic [15:0]             frame_width,
    input  logic                    frame_ready,
    noise_est_block_reader_if.master axi,
    output logic [DATA_WIDTH-1:0]   pixel_out,
    output logic                    noise_estimation_en,
    output logic                    start_of_frame,
    output logic [ADDR_WIDTH-1:0]   base_addr_out,
    output logic                    frame_done
);
    typedef enum logic [2:0] {IDLE, AR, R, NEXT, DONE} state_t;

    localparam logic [15:0]           BS16 = 16'(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BS_A = ADDR_WIDTH'(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BPB  = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                state, state_n;
    logic [15:0]           row, col, line, row_n, col_n, line_n;
    logic [ADDR_WIDTH-1:0] araddr, addr_n;
    logic                  first, beat, last_line, last_col, last_row;

    assign last_line = line == BS16 - 16'd1;
    assign last_col  = col == frame_width / BS16 - 16'd1;
    assign last_row  = row == frame_height / BS16 - 16'd1;
    assign beat      = axi.rvalid && axi.rready;

    assign axi.araddr  = araddr;
    assign axi.arlen   = 8'(BLOCK_SIZE - 1);
    assign axi.arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign axi.arburst = 2'b01;
    assign axi.arvalid = state == AR;
    assign axi.rready  = state == R;
    assign frame_done  = state == DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        line_n  = line;
        case (state)
            IDLE: if (frame_ready) begin
                state_n = AR;
                row_n   = '0;
                col_n   = '0;
                line_n  = '0;
            end
            AR:   state_n = axi.arready ? R : AR;
            R:    state_n = beat && axi.rlast ? NEXT : R;
            NEXT: begin
                line_n  = last_line ? 16'd0 : line + 16'd1;
                col_n   = last_line ? (last_col ? 16'd0 : col + 16'd1) : col;
                row_n   = last_line && last_col ? row + 16'd1 : row;
                state_n = last_line && last_col && last_row ? DONE : AR;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Byte address of the first pixel of the burst about to be issued
    assign addr_n = BASE_ADDR + ((ADDR_WIDTH'(row_n) * BS_A + ADDR_WIDTH'(line_n)) * ADDR_WIDTH'(frame_width)
                    + ADDR_WIDTH'(col_n) * BS_A) * BPB;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row                 <= '0;
            col                 <= '0;
            line                <= '0;
            araddr              <= '0;
            base_addr_out       <= '0;
            pixel_out           <= '0;
            noise_estimation_en <= 1'b0;
            start_of_frame      <= 1'b0;
            first               <= 1'b0;
        end else begin
            row                 <= row_n;
            col                 <= col_n;
            line                <= line_n;
            araddr              <= state_n == AR && state != AR ? addr_n : araddr;
            base_addr_out       <= state_n == AR && state != AR && line_n == 16'd0 ? addr_n : base_addr_out;
            pixel_out           <= beat ? axi.rdata : pixel_out;
            noise_estimation_en <= beat;
            start_of_frame      <= beat && first;
            first               <= state == IDLE && frame_ready ? 1'b1 : beat ? 1'b0 : first;
        end
endmodule

// File: tb/tb_noise_est_block_reader.sv
// tb_noise_est_block_reader: randomized AXI slave plus frame-level reference model for the block reader.
module tb_noise_est_block_reader;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   frame_height = 16'd8;
    logic [15:0]   frame_width = 16'd8;
    logic          frame_ready = 1'b0;
    logic [DW-1:0] pixel_out;
    logic          noise_estimation_en, start_of_frame, frame_done;
    logic [AW-1:0] base_addr_out;

    noise_est_block_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    noise_est_block_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .frame_height(frame_height), .frame_width(frame_width),
        .frame_ready(frame_ready), .axi(axi), .pixel_out(pixel_out),
        .noise_estimation_en(noise_estimation_en), .start_of_frame(start_of_frame),
        .base_addr_out(base_addr_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0]   mem [4096];
    int            ar_delay = 0;
    int            gap_pct = 0;
    logic [AW-1:0] burst_q [$];
    int            beat_idx = 0;
    int            ar_wait = 0;
    logic          hs_ar, hs_r;
    logic [AW-1:0] hs_addr;

    // Memory slave: commits handshakes seen at negedge, drives next-cycle signals just after posedge
    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        forever begin
            @(negedge clk);
            hs_ar   = axi.arvalid && axi.arready;
            hs_r    = axi.rvalid && axi.rready;
            hs_addr = axi.araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                burst_q.delete();
                beat_idx    = 0;
                ar_wait     = 0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                axi.rlast   = 1'b0;
            end else begin
                if (hs_ar) begin
                    burst_q.push_back(hs_addr);
                    ar_wait = 0;
                end
                if (hs_r) begin
                    if (axi.rlast) begin
                        void'(burst_q.pop_front());
                        beat_idx = 0;
                    end else beat_idx++;
                end
                axi.arready = axi.arvalid && ar_wait >= ar_delay;
                if (axi.arvalid && !axi.arready) ar_wait++;
                if (axi.rvalid && !hs_r) begin
                end else if (burst_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = mem[(int'(burst_q[0] >> 2) + beat_idx) % 4096];
                    axi.rlast  = beat_idx == BS - 1;
                    axi.rresp  = 2'($urandom);
                end else begin
                    axi.rvalid = 1'b0;
                    axi.rlast  = 1'b0;
                end
            end
        end
    end

    int            cyc = 0;
    logic [DW-1:0] pix_log [$];
    logic          sof_log [$];
    logic [AW-1:0] ar_log [$];
    logic [AW-1:0] base_log [$];
    int            sof_cnt, stray_sof, done_cnt, unstable, bad_attr, last_pix_cyc, done_cyc;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (prev_wait && (!axi.arvalid || axi.araddr !== prev_addr)) unstable++;
            prev_wait = axi.arvalid && !axi.arready;
            prev_addr = axi.araddr;
            if (axi.arvalid && axi.arready) begin
                ar_log.push_back(axi.araddr);
                base_log.push_back(base_addr_out);
                if (axi.arlen !== 8'd3 || axi.arsize !== 3'd2 || axi.arburst !== 2'd1) bad_attr++;
            end
            if (noise_estimation_en) begin
                pix_log.push_back(pixel_out);
                sof_log.push_back(start_of_frame);
                if (start_of_frame) sof_cnt++;
                last_pix_cyc = cyc;
            end else if (start_of_frame) stray_sof++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else prev_wait = 1'b0;
    end

    logic [AW-1:0] exp_addr [$];
    logic [AW-1:0] exp_base [$];
    logic [DW-1:0] exp_pix [$];
    logic          arv_latency;

    task automatic clear_logs();
        pix_log.delete();
        sof_log.delete();
        ar_log.delete();
        base_log.delete();
        sof_cnt = 0; stray_sof = 0; done_cnt = 0; unstable = 0; bad_attr = 0;
        last_pix_cyc = 0; done_cyc = 0;
    endtask

    // Frame read in raster block order; each block is BS rows of BS consecutive pixels
    task automatic build_model(input int h, input int w);
        exp_addr.delete();
        exp_base.delete();
        exp_pix.delete();
        for (int by = 0; by < h; by += BS)
            for (int bx = 0; bx < w; bx += BS)
                for (int y = by; y < by + BS; y++) begin
                    exp_addr.push_back(AW'(4 * (y * w + bx)));
                    exp_base.push_back(AW'(4 * (by * w + bx)));
                    for (int x = bx; x < bx + BS; x++) exp_pix.push_back(mem[(y * w + x) % 4096]);
                end
    endtask

    function automatic int pix_errs();
        int e = (pix_log.size() != exp_pix.size()) ? 1 : 0;
        for (int i = 0; i < pix_log.size() && i < exp_pix.size(); i++)
            if (pix_log[i] !== exp_pix[i]) e++;
        return e;
    endfunction

    function automatic int addr_errs();
        int e = (ar_log.size() != exp_addr.size()) ? 1 : 0;
        for (int i = 0; i < ar_log.size() && i < exp_addr.size(); i++)
            if (ar_log[i] !== exp_addr[i] || base_log[i] !== exp_base[i]) e++;
        return e;
    endfunction

    task automatic run_frame(input int h, input int w, input int mid);
        frame_height = 16'(h);
        frame_width  = 16'(w);
        build_model(h, w);
        clear_logs();
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        arv_latency = axi.arvalid;
        for (int i = 1; i < 20000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            frame_ready = mid > 0 && i == mid;
        end
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: arvalid=%b rready=%b required 0 0", axi.arvalid, axi.rready);
        end
        n_checks++;
        if ({noise_estimation_en, start_of_frame, frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: en/sof/done=%b required 000", {noise_estimation_en, start_of_frame, frame_done});
        end
        n_checks++;
        if (pixel_out !== '0 || base_addr_out !== '0 || axi.araddr !== '0) begin
            n_fail++;
            $display("FAIL reset_values: pixel=%h base=%h araddr=%h required 0", pixel_out, base_addr_out, axi.araddr);
        end
        n_checks++;
        if ({axi.arlen, axi.arsize, axi.arburst} !== {8'd3, 3'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL reset_ar_attrs: arlen=%0d arsize=%0d arburst=%0d required 3 2 1", axi.arlen, axi.arsize, axi.arburst);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 1);
        ar_delay = 1;
        gap_pct  = 0;
        run_frame(8, 8, 0);
        n_checks++;
        if (arv_latency !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ar_latency: arvalid=%b one cycle after frame_ready, required 1", arv_latency);
        end
        n_checks++;
        if (ar_log.size() !== 16 || addr_errs() !== 0) begin
            n_fail++;
            $display("FAIL basic_addresses: %0d bursts %0d address errors, required 16 and 0", ar_log.size(), addr_errs());
        end
        n_checks++;
        if (ar_log.size() < 5 || ar_log[4] !== 32'd16) begin
            n_fail++;
            $display("FAIL basic_block1_addr: fifth araddr=%0d required 16", ar_log.size() < 5 ? -1 : int'(ar_log[4]));
        end
        n_checks++;
        if (pix_log.size() !== 64 || pix_errs() !== 0) begin
            n_fail++;
            $display("FAIL basic_pixels: %0d pixels %0d errors, required 64 and 0", pix_log.size(), pix_errs());
        end
        n_checks++;
        if (pix_log.size() < 5 || pix_log[0] !== 32'd1 || pix_log[4] !== 32'd9) begin
            n_fail++;
            $display("FAIL basic_pixel_order: first/fifth pixel wrong, required 1 and 9");
        end
        n_checks++;
        if (sof_cnt !== 1 || stray_sof !== 0 || sof_log.size() == 0 || sof_log[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sof: sof count=%0d stray=%0d required 1 on first pixel", sof_cnt, stray_sof);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== last_pix_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: count=%0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc, last_pix_cyc + 1);
        end
        n_checks++;
        if (bad_attr !== 0) begin
            n_fail++;
            $display("FAIL basic_ar_attrs: %0d bursts with wrong arlen/arsize/arburst, required 0", bad_attr);
        end
    endtask

    task automatic test_ar_stall();
        ar_delay = 5;
        gap_pct  = 0;
        run_frame(8, 8, 0);
        n_checks++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL stall_stability: %0d araddr/arvalid changes while stalled, required 0", unstable);
        end
        n_checks++;
        if (ar_log.size() !== 16 || addr_errs() !== 0) begin
            n_fail++;
            $display("FAIL stall_handshakes: %0d handshakes %0d errors, required 16 and 0", ar_log.size(), addr_errs());
        end
        n_checks++;
        if (pix_errs() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL stall_pixels: %0d pixel errors done=%0d, required 0 and 1", pix_errs(), done_cnt);
        end
    endtask

    task automatic test_rgaps();
        for (int k = 0; k < 3; k++) begin
            int h = 4 * int'($urandom_range(1, 4));
            int w = 4 * int'($urandom_range(1, 4));
            for (int i = 0; i < 4096; i++) mem[i] = $urandom;
            ar_delay = int'($urandom_range(0, 3));
            gap_pct  = 40;
            run_frame(h, w, 0);
            n_checks++;
            if (pix_log.size() !== h * w || pix_errs() !== 0) begin
                n_fail++;
                $display("FAIL gaps_pixels_%0dx%0d: %0d pixels %0d errors, required %0d and 0", h, w, pix_log.size(), pix_errs(), h * w);
            end
            n_checks++;
            if (addr_errs() !== 0 || done_cnt !== 1 || sof_cnt !== 1 || stray_sof !== 0) begin
                n_fail++;
                $display("FAIL gaps_frame_%0dx%0d: addr errors=%0d done=%0d sof=%0d, required 0 1 1", h, w, addr_errs(), done_cnt, sof_cnt);
            end
        end
    endtask

    task automatic test_frame_ready_mid();
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        ar_delay = 0;
        gap_pct  = 20;
        run_frame(8, 8, 40);
        n_checks++;
        if (ar_log.size() !== 16 || done_cnt !== 1 || pix_errs() !== 0) begin
            n_fail++;
            $display("FAIL mid_frame_ready: bursts=%0d done=%0d pixel errors=%0d, required 16 1 0", ar_log.size(), done_cnt, pix_errs());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        ar_delay = 0;
        gap_pct  = 0;
        frame_height = 16'd8;
        frame_width  = 16'd8;
        clear_logs();
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        for (int i = 0; i < 2000 && pix_log.size() < 6; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({axi.arvalid, axi.rready, noise_estimation_en, start_of_frame, frame_done} !== 5'b0
            || pixel_out !== '0 || base_addr_out !== '0 || pix_log.size() < 6) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: outputs not cleared at once (pixel=%h, %0d pixels before reset)", pixel_out, pix_log.size());
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (ar_log.size() !== 0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: %0d AR handshakes after release, required 0", ar_log.size());
        end
        run_frame(8, 8, 0);
        n_checks++;
        if (ar_log.size() == 0 || ar_log[0] !== '0 || addr_errs() !== 0 || pix_errs() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: addr errors=%0d pixel errors=%0d done=%0d, required 0 0 1", addr_errs(), pix_errs(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_stall();
        test_rgaps();
        test_frame_ready_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
